// File: rtl/tl_pkg.sv
// Shared light codes, FSM state encodings and lamp-mapping helpers for the
// junction phase scheduler.
package tl_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_e;

    typedef enum logic [2:0] {
        HG   = 3'd0,
        HY   = 3'd1,
        RR1  = 3'd2,
        WALK = 3'd3,
        CG   = 3'd4,
        CY   = 3'd5,
        RR2  = 3'd6
    } state_e;

    // Highway lamp shown while the junction is in state s.
    function automatic light_e hwy_light(input state_e s);
        case (s)
            HG:      return GREEN;
            HY:      return YELLOW;
            default: return RED;
        endcase
    endfunction

    // Country lamp shown while the junction is in state s.
    function automatic light_e cntry_light(input state_e s);
        case (s)
            CG:      return GREEN;
            CY:      return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used as the per-phase dwell timer.
// Ports: clk/rst_n clock and async active-low reset; load/load_val reload the
// count; exp is high while the count is zero (the count holds at zero).
module phase_timer #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned RST_VAL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             exp
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on phase entry, otherwise count down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exp = (cnt_q == '0);

endmodule

// File: rtl/junction_phase_scheduler.sv
// Highway/country junction phase scheduler with pedestrian walk and emergency
// pre-empt. All lamp outputs are flops loaded from the next state, so lamps
// change on the same edge as the state.
// Ports: clock, clear_n (async active-low); x car sensor, ped_req pedestrian
// request, emerg pre-empt; hwy/cntry lamp codes, walk lamp, ped_ack one-cycle
// walk-entry pulse, phase current state encoding.
module junction_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned Y2R_CYC   = 3,
    parameter int unsigned R2G_CYC   = 2,
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_CNTRY = 8,
    parameter int unsigned WALK_CYC  = 5
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    state_e           state_q, state_d;
    logic             ped_pend_q, ped_pend_d;
    logic [1:0]       hwy_q, hwy_d;
    logic [1:0]       cntry_q, cntry_d;
    logic             walk_q, walk_d;
    logic             ped_ack_q, ped_ack_d;
    logic             enter;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;

    // Dwell length minus one for the state being entered.
    function automatic logic [CNT_W-1:0] dwell_m1(input state_e s);
        case (s)
            HG:      return CNT_W'(MIN_GREEN - 1);
            HY:      return CNT_W'(Y2R_CYC - 1);
            RR1:     return CNT_W'(R2G_CYC - 1);
            WALK:    return CNT_W'(WALK_CYC - 1);
            CG:      return CNT_W'(MAX_CNTRY - 1);
            CY:      return CNT_W'(Y2R_CYC - 1);
            default: return CNT_W'(R2G_CYC - 1);
        endcase
    endfunction

    phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(MIN_GREEN - 1)
    ) u_timer (
        .clk     (clock),
        .rst_n   (clear_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .exp     (tmr_exp)
    );

    // Next-state, pending-request and registered-output logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: begin
                if (tmr_exp && !emerg && (x || ped_pend_q)) state_d = HY;
            end
            HY: begin
                if (tmr_exp) state_d = RR1;
            end
            RR1: begin
                // Priority: emergency, then pedestrian, then country car.
                if (tmr_exp) begin
                    if (emerg)           state_d = RR2;
                    else if (ped_pend_q) state_d = WALK;
                    else if (x)          state_d = CG;
                    else                 state_d = RR2;
                end
            end
            WALK: begin
                if (emerg)        state_d = RR2;
                else if (tmr_exp) state_d = x ? CG : RR2;
            end
            CG: begin
                if (!x || tmr_exp || emerg) state_d = CY;
            end
            CY: begin
                if (tmr_exp) state_d = RR2;
            end
            RR2: begin
                if (tmr_exp) state_d = HG;
            end
            default: state_d = RR2;
        endcase

        enter    = (state_d != state_q);
        tmr_load = enter;
        tmr_val  = dwell_m1(state_d);

        // A request seen on the walk-entry edge is served by that walk.
        if (enter && (state_d == WALK)) ped_pend_d = 1'b0;
        else                            ped_pend_d = ped_pend_q | ped_req;

        hwy_d     = hwy_light(state_d);
        cntry_d   = cntry_light(state_d);
        walk_d    = (state_d == WALK);
        ped_ack_d = enter && (state_d == WALK);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= HG;
            ped_pend_q <= 1'b0;
            hwy_q      <= GREEN;
            cntry_q    <= RED;
            walk_q     <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            hwy_q      <= hwy_d;
            cntry_q    <= cntry_d;
            walk_q     <= walk_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    assign hwy     = hwy_q;
    assign cntry   = cntry_q;
    assign walk    = walk_q;
    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Scoreboard bench for junction_phase_scheduler: directed scenarios plus
// random traffic, checked against a phase/elapsed-time reference model.
module tb_junction_phase_scheduler;
    import tl_pkg::*;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    junction_phase_scheduler dut (
        .clock  (clock),
        .clear_n(clear_n),
        .x      (x),
        .ped_req(ped_req),
        .emerg  (emerg),
        .hwy    (hwy),
        .cntry  (cntry),
        .walk   (walk),
        .ped_ack(ped_ack),
        .phase  (phase)
    );

    always #5 clock = ~clock;

    typedef enum int {M_HG, M_HY, M_RR1, M_WALK, M_CG, M_CY, M_RR2} mph_e;

    typedef struct packed {
        logic [1:0] h;
        logic [1:0] c;
        logic       w;
        logic       a;
        logic [2:0] ph;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;

    mph_e  m_st;
    int    m_ela;
    bit    m_pend;

    int f_hy, f_rr1, f_cg, f_cy, f_rr2, f_hg2;
    int n_walk, n_ack;

    function automatic int dwell(input mph_e s);
        case (s)
            M_HG:   return 4;
            M_HY:   return 3;
            M_RR1:  return 2;
            M_WALK: return 5;
            M_CG:   return 8;
            M_CY:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] code_of(input mph_e s);
        case (s)
            M_HG:   return 3'(HG);
            M_HY:   return 3'(HY);
            M_RR1:  return 3'(RR1);
            M_WALK: return 3'(WALK);
            M_CG:   return 3'(CG);
            M_CY:   return 3'(CY);
            default: return 3'(RR2);
        endcase
    endfunction

    function automatic void m_reset();
        m_st   = M_HG;
        m_ela  = 0;
        m_pend = 1'b0;
    endfunction

    // One clock edge of the reference junction; pushes the lamps expected after it.
    function automatic void m_step(input bit xi, input bit pi, input bit ei);
        mph_e nxt;
        bit   ex;
        bit   ent;
        exp_t e;
        nxt = m_st;
        ex  = (m_ela >= dwell(m_st) - 1);
        case (m_st)
            M_HG:   if (ex && !ei && (xi || m_pend)) nxt = M_HY;
            M_HY:   if (ex) nxt = M_RR1;
            M_RR1:  if (ex) nxt = ei ? M_RR2 : (m_pend ? M_WALK : (xi ? M_CG : M_RR2));
            M_WALK: if (ei) nxt = M_RR2; else if (ex) nxt = xi ? M_CG : M_RR2;
            M_CG:   if (!xi || ex || ei) nxt = M_CY;
            M_CY:   if (ex) nxt = M_RR2;
            default: if (ex) nxt = M_HG;
        endcase
        ent    = (nxt != m_st);
        m_pend = (ent && nxt == M_WALK) ? 1'b0 : (m_pend | pi);
        m_ela  = ent ? 0 : m_ela + 1;
        m_st   = nxt;
        e.h  = (nxt == M_HG) ? 2'd2 : ((nxt == M_HY) ? 2'd1 : 2'd0);
        e.c  = (nxt == M_CG) ? 2'd2 : ((nxt == M_CY) ? 2'd1 : 2'd0);
        e.w  = (nxt == M_WALK);
        e.a  = ent && (nxt == M_WALK);
        e.ph = code_of(nxt);
        sb_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cyc_now(input bit xi, input bit pi, input bit ei);
        x = xi; ped_req = pi; emerg = ei;
        m_step(xi, pi, ei);
    endtask

    task automatic cyc(input bit xi, input bit pi, input bit ei);
        @(negedge clock);
        cyc_now(xi, pi, ei);
    endtask

    task automatic go_to(input mph_e tgt, input bit xi, input bit pi, input bit ei, input int maxc);
        int n;
        n = 0;
        while (m_st != tgt && n < maxc) begin
            cyc(xi, pi, ei);
            n++;
        end
        if (m_st != tgt) begin
            checks++;
            errors++;
            $display("FAIL nav target=%0d not reached within %0d cycles", int'(tgt), maxc);
        end
    endtask

    // Async reset between edges; lamps must return to highway green at once.
    task automatic do_reset();
        @(posedge clock);
        #3;
        clear_n = 1'b0;
        #1;
        chk("rst_hwy", int'(hwy), 2);
        chk("rst_cntry", int'(cntry), 0);
        chk("rst_walk", int'(walk), 0);
        chk("rst_ack", int'(ped_ack), 0);
        chk("rst_phase", int'(phase), int'(HG));
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        x = 1'b0; ped_req = 1'b0; emerg = 1'b0;
        m_reset();
    endtask

    // Monitor: compare every post-edge output against the scoreboard and the safety rule.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (clear_n) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("hwy", int'(hwy), int'(e.h));
                    chk("cntry", int'(cntry), int'(e.c));
                    chk("walk", int'(walk), int'(e.w));
                    chk("ped_ack", int'(ped_ack), int'(e.a));
                    chk("phase", int'(phase), int'(e.ph));
                end
                chk("safety", ((hwy != 2'd0 && cntry != 2'd0) ||
                               (walk && (hwy != 2'd0 || cntry != 2'd0))) ? 1 : 0, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rx, re;
        m_reset();

        // Reset and idle.
        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("init_hwy", int'(hwy), 2);
        chk("init_cntry", int'(cntry), 0);
        chk("init_phase", int'(phase), int'(HG));
        @(negedge clock);
        clear_n = 1'b1;
        m_reset();
        cyc_now(1'b0, 1'b0, 1'b0);
        repeat (49) cyc(1'b0, 1'b0, 1'b0);

        // Country car held: edge numbers of each phase entry.
        do_reset();
        f_hy = -1; f_rr1 = -1; f_cg = -1; f_cy = -1; f_rr2 = -1; f_hg2 = -1;
        cyc_now(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 24; e++) begin
            @(posedge clock);
            #2;
            if (phase == HY  && f_hy  < 0) f_hy  = e;
            if (phase == RR1 && f_rr1 < 0) f_rr1 = e;
            if (phase == CG  && f_cg  < 0) f_cg  = e;
            if (phase == CY  && f_cy  < 0) f_cy  = e;
            if (phase == RR2 && f_rr2 < 0) f_rr2 = e;
            if (phase == HG  && f_cg > 0 && f_hg2 < 0) f_hg2 = e;
            cyc(1'b1, 1'b0, 1'b0);
        end
        chk("car_hy_edge", f_hy, 4);
        chk("car_rr1_edge", f_rr1, 7);
        chk("car_cg_edge", f_cg, 9);
        chk("car_cy_edge", f_cy, 17);
        chk("car_rr2_edge", f_rr2, 20);
        chk("car_hg_edge", f_hg2, 22);

        // Pedestrian pulse, no car.
        do_reset();
        n_walk = 0; n_ack = 0;
        cyc_now(1'b0, 1'b1, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock);
            #2;
            if (walk)    n_walk++;
            if (ped_ack) n_ack++;
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("ped_walk_cycles", n_walk, 5);
        chk("ped_ack_pulses", n_ack, 1);
        chk("ped_back_hg", int'(phase), int'(HG));

        // Pedestrian and car together, then the car leaves mid-CG.
        do_reset();
        cyc_now(1'b1, 1'b1, 1'b0);
        go_to(M_CG, 1'b1, 1'b0, 1'b0, 40);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);

        // Emergency raised mid-CG.
        do_reset();
        cyc_now(1'b1, 1'b0, 1'b0);
        go_to(M_CG, 1'b1, 1'b0, 1'b0, 40);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);

        // Emergency raised in WALK; HG must hold while emerg stays high.
        do_reset();
        cyc_now(1'b0, 1'b1, 1'b0);
        go_to(M_WALK, 1'b0, 1'b0, 1'b0, 30);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #2;
        chk("emerg_hold_hg", int'(phase), int'(HG));
        repeat (10) cyc(1'b1, 1'b0, 1'b0);

        // Async reset while in CG.
        do_reset();
        cyc_now(1'b1, 1'b0, 1'b0);
        go_to(M_CG, 1'b1, 1'b0, 1'b0, 40);
        cyc(1'b1, 1'b0, 1'b0);
        do_reset();

        // Random traffic.
        cyc_now(1'b0, 1'b0, 1'b0);
        rx = 1'b0; re = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0)  rx = ~rx;
            if ($urandom_range(0, 39) == 0) re = ~re;
            cyc(rx, ($urandom_range(0, 19) == 0), re);
        end

        @(posedge clock);
        #3;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain leftover=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
